snes_video_pattern_gen: RTL and testbench
=========================================

// Module: snes_video_pattern_gen
// PURPOSE
//  Source-side counterpart of the SNES-to-VGA retimer. From one system clock it
//  produces a SNES-style video stream: dot_clock, input_valid, hsync, vblank and
//  24-bit RGB. The stream drives the retimer input directly, standing in for the PPU
//  during bring-up and for loop-back tests. Four selectable test patterns.
// PARAMETERS
//  CLK_DIV      4    clocks per dot; must be >= 2; dot_clock high for CLK_DIV/2 clocks
//  H_ACTIVE     256  active dots per line
//  H_TOTAL      341  dots per line
//  HSYNC_START  274  first dot with hsync high
//  HSYNC_LEN    25   hsync width in dots
//  V_ACTIVE     224  active lines per frame
//  V_TOTAL      262  lines per frame
// PORTS
//  clk          in   1   system clock (same domain as retimer input_clk)
//  reset        in   1   asynchronous, active-high
//  en           in   1   run enable; 0 freezes generator
//  mode         in   2   0 bars, 1 grid, 2 ramp, 3 solid
//  solid_rgb    in   24  {R,G,B} for mode 3
//  dot_clock    out  1   dot clock, square wave, period CLK_DIV clocks
//  R_out        out  8   red
//  G_out        out  8   green
//  B_out        out  8   blue
//  output_valid out  1   dot is inside the active area
//  hsync_out    out  1   horizontal sync, active-high
//  vblank_out   out  1   vertical blank, active-high
//  frame_start  out  1   one-clock pulse at dot (0,0)
//  frame_ctr    out  8   frame counter, wraps 255->0
// BEHAVIOUR
//  - Reset values: phase=0, hcount=0, vcount=0, frame_ctr=0, mode_q=0, all outputs 0
//    except vblank_out=1.
//  - First dot period (0,0) begins on the first en=1 clock after reset release.
//  - phase counts 0..CLK_DIV-1 while en=1. dot_clock is registered: 1 for
//    phase<CLK_DIV/2, else 0.
//  - Each dot period begins on the clock phase goes to 0. On that clock
//    R/G/B/valid/hsync/vblank all register together. They then hold for CLK_DIV
//    clocks, so data is stable at and after every dot_clock rising edge.
//  - hcount 0..H_TOTAL-1 advances once per dot. vcount advances when hcount wraps.
//  - vcount wraps at V_TOTAL-1. On that wrap frame_ctr increments mod 256.
//  - valid = hcount<H_ACTIVE && vcount<V_ACTIVE.
//  - hsync = HSYNC_START <= hcount < HSYNC_START+HSYNC_LEN. hsync is generated on
//    every line, including vblank lines.
//  - vblank = vcount>=V_ACTIVE. R/G/B are 0 whenever valid=0.
//  - mode is sampled into mode_q only at the start of dot (0,0). Mid-frame mode
//    changes therefore never tear the frame. solid_rgb is sampled live.
//  - frame_start is high for the single clock that starts dot (0,0).
//  - Patterns, with x = pattern x-coordinate (see CONFIGURATION), 8 bits:
//    * bars: i=x[7:5]; R={8{i[2]}}, G={8{i[1]}}, B={8{i[0]}}
//    * grid: FFFFFF if x[2:0]==0 or vcount[2:0]==0, else 000000
//    * ramp: R=x, G=vcount[7:0], B=frame_ctr
//    * solid: solid_rgb
//  - en=0: phase, counters and all outputs hold, except dot_clock is forced 0.
//    On resume, the interrupted dot completes its remaining phases; no dot is lost
//    or duplicated.
//  - Reset asserted mid-frame clears state immediately (asynchronous). No partial
//    pulse is stretched across reset.
//  - Counters are 9 bits wide; parameters must fit in 9 bits.
// CONFIGURATION
//  SNES_PATGEN_SCROLL_EN defined: x = hcount[7:0] + frame_ctr (mod 256), so patterns
//    scroll one dot per frame in modes 0-2.
//  SNES_PATGEN_SCROLL_EN undefined: x = hcount[7:0].
//  In both cases valid, hsync and vblank timing are unaffected.
// TESTING
//  1 Reset release, en=1, mode=0, CLK_DIV=4:
//    -> dot_clock 1,1,0,0 repeating
//    -> dot0 valid=1, RGB=000000; dot32 RGB=0000FF; dot255 RGB=FFFFFF
//    -> dot256 valid=0, RGB=000000
//  2 Run 2 frames:
//    -> hsync high on dots 274..298 of every line
//    -> 224 lines with valid, vblank high on lines 224..261
//    -> frame_start interval 341*262*4 = 357368 clocks; frame_ctr 0->1->2
//  3 Switch mode 0->3 at line 100, solid_rgb=123456:
//    -> rest of frame still bars
//    -> every active dot of the next frame = 123456
//  4 en=0 for 10 clocks at phase 1 of dot 50:
//    -> dot_clock 0 and all outputs frozen
//    -> resume finishes dot 50 in 3 more clocks; next dot is 51
//  5 reset pulse mid-line 120:
//    -> same cycle: outputs 0, vblank=1
//    -> after release, frame_start precedes dot (0,0)
//  6 mode=2, frame 1, dot 0, line 0:
//    -> with SNES_PATGEN_SCROLL_EN: R=01; without: R=00

Source files
------------

// File: rtl/snes_video_pattern_gen_if.sv
// Video-source bundle between snes_video_pattern_gen (master) and its consumer (slave).
// Run controls flow into the generator; the SNES-style dot stream flows out.
interface snes_video_pattern_gen_if;
  logic       en;
  logic [1:0] mode;
  logic [23:0] solid_rgb;
  logic       dot_clock;
  logic [7:0] R_out;
  logic [7:0] G_out;
  logic [7:0] B_out;
  logic       output_valid;
  logic       hsync_out;
  logic       vblank_out;
  logic       frame_start;
  logic [7:0] frame_ctr;

  modport master (
    input  en, mode, solid_rgb,
    output dot_clock, R_out, G_out, B_out, output_valid, hsync_out, vblank_out,
           frame_start, frame_ctr
  );

  modport slave (
    output en, mode, solid_rgb,
    input  dot_clock, R_out, G_out, B_out, output_valid, hsync_out, vblank_out,
           frame_start, frame_ctr
  );
endinterface

// File: rtl/snes_video_pattern_gen.sv
// SNES-style test-pattern source: dot clock, sync/blank and bars/grid/ramp/solid RGB.
// Define SNES_PATGEN_SCROLL_EN to scroll the pattern x-coordinate one dot per frame.
module snes_video_pattern_gen #(
  parameter int CLK_DIV     = 4,
  parameter int H_ACTIVE    = 256,
  parameter int H_TOTAL     = 341,
  parameter int HSYNC_START = 274,
  parameter int HSYNC_LEN   = 25,
  parameter int V_ACTIVE    = 224,
  parameter int V_TOTAL     = 262
) (
  input logic clk,
  input logic reset,
  snes_video_pattern_gen_if.master vid
);
  localparam int CW = 9;
  localparam int PW = $clog2(CLK_DIV);

  logic [PW-1:0] phase_p0;
  logic [CW-1:0] hcount_p0;
  logic [CW-1:0] vcount_p0;
  logic [7:0]    frame_ctr_p0;
  logic [1:0]    mode_q;

  logic          dot_start;
  logic          phase_last;
  logic          origin;
  logic          h_last;
  logic          v_last;
  logic [1:0]    mode_sel;
  logic [7:0]    x;
  logic          vld_next;
  logic          hs_next;
  logic          vb_next;
  logic [23:0]   rgb_next;

  logic [23:0]   rgb_p1;
  logic          vld_p1;
  logic          hs_p1;
  logic          vb_p1;
  logic          dclk_p1;
  logic          fs_p1;

  function automatic logic [23:0] pattern(input logic [1:0] m, input logic [7:0] px,
                                          input logic [7:0] py, input logic [7:0] pf,
                                          input logic [23:0] solid);
    logic [23:0] p;
    unique case (m)
      2'd0:    p = {{8{px[7]}}, {8{px[6]}}, {8{px[5]}}};
      2'd1:    p = (px[2:0] == 3'd0 || py[2:0] == 3'd0) ? 24'hFFFFFF : 24'h000000;
      2'd2:    p = {px, py, pf};
      default: p = solid;
    endcase
    return p;
  endfunction

  // Stage p0: dot timing counters and the attributes of the dot about to start
  always_comb begin
    phase_last = (phase_p0 == PW'(CLK_DIV - 1));
    dot_start  = vid.en && (phase_p0 == '0);
    h_last     = (hcount_p0 == CW'(H_TOTAL - 1));
    v_last     = (vcount_p0 == CW'(V_TOTAL - 1));
    origin     = (hcount_p0 == '0) && (vcount_p0 == '0);
    // The mode for a new frame takes effect on its very first dot.
    mode_sel   = origin ? vid.mode : mode_q;
`ifdef SNES_PATGEN_SCROLL_EN
    x          = hcount_p0[7:0] + frame_ctr_p0;
`else
    x          = hcount_p0[7:0];
`endif
    vld_next   = (hcount_p0 < CW'(H_ACTIVE)) && (vcount_p0 < CW'(V_ACTIVE));
    hs_next    = (hcount_p0 >= CW'(HSYNC_START)) &&
                 (hcount_p0 < CW'(HSYNC_START + HSYNC_LEN));
    vb_next    = (vcount_p0 >= CW'(V_ACTIVE));
    rgb_next   = vld_next ? pattern(mode_sel, x, vcount_p0[7:0], frame_ctr_p0, vid.solid_rgb)
                          : 24'h000000;
  end

  // Stage p1: registered video outputs, updated once per dot and held for CLK_DIV clocks
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_p0     <= '0;
      hcount_p0    <= '0;
      vcount_p0    <= '0;
      frame_ctr_p0 <= '0;
      mode_q       <= '0;
      rgb_p1       <= '0;
      vld_p1       <= 1'b0;
      hs_p1        <= 1'b0;
      vb_p1        <= 1'b1;
      dclk_p1      <= 1'b0;
      fs_p1        <= 1'b0;
    end else begin
      fs_p1 <= dot_start && origin;
      if (vid.en) begin
        phase_p0 <= phase_last ? '0 : phase_p0 + PW'(1);
        dclk_p1  <= (phase_p0 < PW'(CLK_DIV / 2));
      end else begin
        dclk_p1  <= 1'b0;
      end
      if (dot_start) begin
        rgb_p1    <= rgb_next;
        vld_p1    <= vld_next;
        hs_p1     <= hs_next;
        vb_p1     <= vb_next;
        if (origin) mode_q <= vid.mode;
        hcount_p0 <= h_last ? '0 : hcount_p0 + CW'(1);
        if (h_last) begin
          vcount_p0 <= v_last ? '0 : vcount_p0 + CW'(1);
          if (v_last) frame_ctr_p0 <= frame_ctr_p0 + 8'd1;
        end
      end
    end
  end

  assign vid.dot_clock    = dclk_p1;
  assign vid.R_out        = rgb_p1[23:16];
  assign vid.G_out        = rgb_p1[15:8];
  assign vid.B_out        = rgb_p1[7:0];
  assign vid.output_valid = vld_p1;
  assign vid.hsync_out    = hs_p1;
  assign vid.vblank_out   = vb_p1;
  assign vid.frame_start  = fs_p1;
  assign vid.frame_ctr    = frame_ctr_p0;

endmodule

// File: tb/tb_snes_video_pattern_gen.sv
// Bench for snes_video_pattern_gen: vector table, corner sequences and a
// dot-index reference model checked every clock on a reduced raster.
module tb_snes_video_pattern_gen;
  localparam int CD  = 4;
  localparam int HA  = 256;
  localparam int HT  = 300;
  localparam int HSS = 270;
  localparam int HSL = 10;
  localparam int VA  = 4;
  localparam int VT  = 6;
  localparam int FS  = HT * VT;
  localparam int NV  = 16;

  logic clk = 1'b0;
  logic rst;

  snes_video_pattern_gen_if vif ();

  snes_video_pattern_gen #(
    .CLK_DIV(CD), .H_ACTIVE(HA), .H_TOTAL(HT), .HSYNC_START(HSS),
    .HSYNC_LEN(HSL), .V_ACTIVE(VA), .V_TOTAL(VT)
  ) dut (
    .clk(clk),
    .reset(rst),
    .vid(vif)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;

  // Reference model state: enabled clocks since reset fully determine the raster position.
  int unsigned en_clks;
  logic [1:0]  m_mode;
  logic [23:0] e_rgb;
  logic        e_vld, e_hs, e_vb, e_dclk, e_fs;
  logic [7:0]  e_fctr;
  bit          model_on = 1'b1;
  bit          fs_meas = 1'b0;
  int          cyc = 0;
  int          last_fs = -1;

  typedef struct {
    logic [1:0]  mode;
    logic [23:0] solid;
    int          f;
    int          l;
    int          d;
    logic [23:0] rgb;
    logic        vld;
    logic        hs;
    logic        vb;
  } vec_t;

  vec_t tbl[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      if (failed <= 30) $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] ref_rgb(input int m, input int px, input int py, input int pf,
                                          input logic [23:0] solid);
    int i;
    i = px / 32;
    case (m)
      0: return {((i / 4) % 2 != 0) ? 8'hFF : 8'h00,
                 ((i / 2) % 2 != 0) ? 8'hFF : 8'h00,
                 (i % 2 != 0)       ? 8'hFF : 8'h00};
      1: return ((px % 8) == 0 || (py % 8) == 0) ? 24'hFFFFFF : 24'h000000;
      2: return {8'(px), 8'(py), 8'(pf)};
      default: return solid;
    endcase
  endfunction

  function automatic void model_reset();
    en_clks = 0;
    m_mode  = 2'd0;
    e_rgb   = 24'h0;
    e_vld   = 1'b0;
    e_hs    = 1'b0;
    e_vb    = 1'b1;
    e_dclk  = 1'b0;
    e_fs    = 1'b0;
    e_fctr  = 8'h0;
  endfunction

  task automatic model_edge();
    int ph, d, dot, line, fr, px;
    if (rst) begin
      model_reset();
      return;
    end
    e_fs = 1'b0;
    if (!vif.en) begin
      e_dclk = 1'b0;
      return;
    end
    ph = int'(en_clks % CD);
    d  = int'(en_clks / CD);
    e_dclk = (ph < CD / 2);
    if (ph == 0) begin
      dot  = d % HT;
      line = (d / HT) % VT;
      fr   = d / FS;
      if (dot == 0 && line == 0) begin
        m_mode = vif.mode;
        e_fs   = 1'b1;
      end
      e_vld = (dot < HA) && (line < VA);
      e_hs  = (dot >= HSS) && (dot < HSS + HSL);
      e_vb  = (line >= VA);
      px    = dot;
`ifdef SNES_PATGEN_SCROLL_EN
      px    = dot + fr;
`endif
      e_rgb  = e_vld ? ref_rgb(int'(m_mode), px % 256, line % 256, fr % 256, vif.solid_rgb)
                     : 24'h0;
      e_fctr = 8'((d + 1) / FS);
    end
    en_clks++;
  endtask

  task automatic model_check();
    chk("model_rgb", {8'h0, vif.R_out, vif.G_out, vif.B_out}, {8'h0, e_rgb});
    chk("model_valid", 32'(vif.output_valid), 32'(e_vld));
    chk("model_hsync", 32'(vif.hsync_out), 32'(e_hs));
    chk("model_vblank", 32'(vif.vblank_out), 32'(e_vb));
    chk("model_dot_clock", 32'(vif.dot_clock), 32'(e_dclk));
    chk("model_frame_start", 32'(vif.frame_start), 32'(e_fs));
    chk("model_frame_ctr", 32'(vif.frame_ctr), 32'(e_fctr));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    if (model_on) model_check();
    if (fs_meas && vif.frame_start) begin
      if (last_fs >= 0) chk("frame_start_interval", 32'(cyc - last_fs), 32'(FS * CD));
      last_fs = cyc;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vif.en = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic run_to(input int f, input int l, input int d);
    int target;
    int guard;
    target = (f * FS + l * HT + d) * CD + 1;
    guard = 0;
    while (int'(en_clks) < target && guard < 20000) begin
      step();
      guard++;
    end
    if (guard >= 20000) begin
      tests++;
      failed++;
      $display("FAIL run_to: target %0d not reached, got %0d", target, en_clks);
    end
  endtask

  function automatic logic [31:0] rgb_now();
    return {8'h0, vif.R_out, vif.G_out, vif.B_out};
  endfunction

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d cycles, expected fewer", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] dclk_seq;
    rst = 1'b1;
    vif.en = 1'b0;
    vif.mode = 2'd0;
    vif.solid_rgb = 24'h0;
    model_reset();

    tbl[0]  = '{2'd0, 24'h0, 0, 0, 0,   24'h000000, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{2'd0, 24'h0, 0, 0, 32,  24'h0000FF, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{2'd0, 24'h0, 0, 0, 100, 24'h00FFFF, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{2'd0, 24'h0, 0, 0, 255, 24'hFFFFFF, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{2'd0, 24'h0, 0, 0, 256, 24'h000000, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{2'd0, 24'h0, 0, 0, 269, 24'h000000, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{2'd0, 24'h0, 0, 0, 270, 24'h000000, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{2'd0, 24'h0, 0, 0, 279, 24'h000000, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{2'd0, 24'h0, 0, 0, 280, 24'h000000, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{2'd1, 24'h0, 0, 0, 9,   24'hFFFFFF, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{2'd1, 24'h0, 0, 1, 8,   24'hFFFFFF, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{2'd1, 24'h0, 0, 1, 9,   24'h000000, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{2'd2, 24'h0, 0, 3, 77,  24'h4D0300, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{2'd3, 24'hA5C3E1, 0, 2, 5, 24'hA5C3E1, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{2'd3, 24'hA5C3E1, 0, 5, 272, 24'h000000, 1'b0, 1'b1, 1'b1};
`ifdef SNES_PATGEN_SCROLL_EN
    tbl[15] = '{2'd2, 24'h0, 1, 0, 0,   24'h010001, 1'b1, 1'b0, 1'b0};
`else
    tbl[15] = '{2'd2, 24'h0, 1, 0, 0,   24'h000001, 1'b1, 1'b0, 1'b0};
`endif

    // Reset values
    do_reset();
    chk("reset_rgb", rgb_now(), 32'h0);
    chk("reset_valid", 32'(vif.output_valid), 32'h0);
    chk("reset_hsync", 32'(vif.hsync_out), 32'h0);
    chk("reset_vblank", 32'(vif.vblank_out), 32'h1);
    chk("reset_dot_clock", 32'(vif.dot_clock), 32'h0);
    chk("reset_frame_start", 32'(vif.frame_start), 32'h0);
    chk("reset_frame_ctr", 32'(vif.frame_ctr), 32'h0);

    // dot_clock 1,1,0,0 repeating; frame_start only with the first dot
    vif.en = 1'b1;
    dclk_seq = 4'b0011;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("dot_clock_seq%0d", i), 32'(vif.dot_clock), 32'(dclk_seq[i % 4]));
      chk($sformatf("frame_start_seq%0d", i), 32'(vif.frame_start), (i == 0) ? 32'h1 : 32'h0);
    end

    // Vector table
    for (int k = 0; k < NV; k++) begin
      do_reset();
      vif.mode = tbl[k].mode;
      vif.solid_rgb = tbl[k].solid;
      vif.en = 1'b1;
      run_to(tbl[k].f, tbl[k].l, tbl[k].d);
      chk($sformatf("vec%0d_rgb", k), rgb_now(), {8'h0, tbl[k].rgb});
      chk($sformatf("vec%0d_valid", k), 32'(vif.output_valid), 32'(tbl[k].vld));
      chk($sformatf("vec%0d_hsync", k), 32'(vif.hsync_out), 32'(tbl[k].hs));
      chk($sformatf("vec%0d_vblank", k), 32'(vif.vblank_out), 32'(tbl[k].vb));
    end

    // en=0 at phase 1 of dot 50
    do_reset();
    vif.mode = 2'd2;
    vif.solid_rgb = 24'h0;
    vif.en = 1'b1;
    run_to(0, 0, 50);
    chk("freeze_pre_R", 32'(vif.R_out), 32'h32);
    vif.en = 1'b0;
    repeat (10) step();
    chk("freeze_dot_clock", 32'(vif.dot_clock), 32'h0);
    chk("freeze_R", 32'(vif.R_out), 32'h32);
    chk("freeze_valid", 32'(vif.output_valid), 32'h1);
    vif.en = 1'b1;
    repeat (3) step();
    chk("resume_dot50_R", 32'(vif.R_out), 32'h32);
    step();
    chk("resume_dot51_R", 32'(vif.R_out), 32'h33);
    chk("resume_dot51_dclk", 32'(vif.dot_clock), 32'h1);

    // Mid-frame mode switch takes effect at the next frame only
    do_reset();
    vif.mode = 2'd0;
    vif.en = 1'b1;
    run_to(0, 2, 0);
    vif.mode = 2'd3;
    vif.solid_rgb = 24'h123456;
    run_to(0, 3, 100);
    chk("modesw_same_frame", rgb_now(), 32'h0000FFFF);
    run_to(1, 0, 100);
    chk("modesw_next_frame_a", rgb_now(), 32'h00123456);
    run_to(1, 2, 120);
    chk("modesw_next_frame_b", rgb_now(), 32'h00123456);
    chk("modesw_frame_ctr", 32'(vif.frame_ctr), 32'h1);

    // Asynchronous reset mid-line
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("areset_rgb", rgb_now(), 32'h0);
    chk("areset_valid", 32'(vif.output_valid), 32'h0);
    chk("areset_vblank", 32'(vif.vblank_out), 32'h1);
    chk("areset_frame_ctr", 32'(vif.frame_ctr), 32'h0);
    @(negedge clk);
    step();
    rst = 1'b0;
    step();
    chk("areset_restart_fs", 32'(vif.frame_start), 32'h1);
    chk("areset_restart_valid", 32'(vif.output_valid), 32'h1);
    step();
    chk("areset_restart_fs_low", 32'(vif.frame_start), 32'h0);

    // Randomized run: two full frames with en held high, then random en gaps
    do_reset();
    vif.mode = 2'($urandom_range(0, 3));
    vif.en = 1'b1;
    last_fs = -1;
    fs_meas = 1'b1;
    for (int i = 0; i < 2 * FS * CD + 100; i++) begin
      vif.solid_rgb = 24'($urandom);
      if ($urandom_range(0, 299) == 0) vif.mode = 2'($urandom_range(0, 3));
      step();
    end
    fs_meas = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      vif.en = ($urandom_range(0, 3) != 0);
      vif.solid_rgb = 24'($urandom);
      if ($urandom_range(0, 299) == 0) vif.mode = 2'($urandom_range(0, 3));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
